fifo_stream_reader: RTL and testbench



---
 rtl/fifo_stream_reader.sv | 106 ++++++++++
 tb/tb_fifo_stream_reader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
//
// Drains the team's synchronous FIFO onto a valid/ready stream. The block
// issues read strobes, absorbs the FIFO's one-cycle registered read latency
// with an in-flight bit, and captures each returned word into a 2-entry
// output buffer whose head drives the stream.
//
// A read is issued only when the word it returns is certain to have a free
// buffer slot. The check counts words already buffered, the word in flight
// and a pop happening on this same edge. Because of that last term, the
// strobe has a combinational path from m_ready, which lets the block sustain
// one word per clock against an always-ready consumer.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   en         in   read enable; 0 stops new FIFO reads
//   fifo_empty in   FIFO empty flag
//   fifo_data  in   FIFO data_out, valid the cycle after an accepted read
//   fifo_rd_en out  FIFO read strobe (forced low while rst=1)
//   m_valid    out  stream valid (output buffer not empty)
//   m_ready    in   consumer ready
//   m_data     out  stream data, head of the output buffer
//   words_out  out  count of words handed off, wraps modulo 2^Count_Width
// ---------------------------------------------------------------------------
module fifo_stream_reader #(
  parameter int Data_Width  = 16,
  parameter int Count_Width = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   fifo_empty,
  input  logic [Data_Width-1:0]  fifo_data,
  output logic                   fifo_rd_en,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [Data_Width-1:0]  m_data,
  output logic [Count_Width-1:0] words_out
);

  logic                   vld_p0;
  logic [1:0]             occ_p1;
  logic [Data_Width-1:0]  buf0_p1;
  logic [Data_Width-1:0]  buf1_p1;
  logic [Count_Width-1:0] cnt;

  logic                   pop;
  logic [2:0]             committed;
  logic [1:0]             occ_nxt;
  logic [Data_Width-1:0]  buf0_nxt;
  logic [Data_Width-1:0]  buf1_nxt;

  assign m_valid   = (occ_p1 != 2'd0);
  assign m_data    = buf0_p1;
  assign words_out = cnt;
  assign pop       = m_valid && m_ready;

  // Slots that stay claimed after this edge; occupancy >= 1 whenever pop=1,
  // so the subtraction never underflows.
  assign committed  = {1'b0, occ_p1} + {2'b00, vld_p0} - {2'b00, pop};
  assign fifo_rd_en = en && !fifo_empty && !rst && (committed <= 3'd1);

  // Buffer next state: a pop shifts the tail into the head, then a captured
  // word lands in the first free slot left after that shift.
  always_comb begin
    occ_nxt  = occ_p1 + {1'b0, vld_p0} - {1'b0, pop};
    buf0_nxt = pop ? buf1_p1 : buf0_p1;
    buf1_nxt = buf1_p1;
    if (vld_p0) begin
      if ((occ_p1 - {1'b0, pop}) == 2'd0) begin
        buf0_nxt = fifo_data;
      end else begin
        buf1_nxt = fifo_data;
      end
    end
  end

  // ---- p0: FIFO read issued, word in flight ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= fifo_rd_en;
    end
  end

  // ---- p1: word captured into the output buffer ----
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_p1  <= 2'd0;
      buf0_p1 <= '0;
      cnt     <= '0;
    end else begin
      occ_p1  <= occ_nxt;
      buf0_p1 <= buf0_nxt;
      cnt     <= cnt + {{(Count_Width-1){1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    buf1_p1 <= buf1_nxt;
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [CW-1:0] words_out;

  fifo_stream_reader #(.Data_Width(DW), .Count_Width(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .words_out (words_out)
  );

  always #5 clk = ~clk;

  // FIFO contents (environment) and reference model state
  logic [DW-1:0] fq[$];
  logic [DW-1:0] mq[$];
  bit            infl = 0;
  logic [DW-1:0] infl_word = '0;
  int            mcnt = 0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int reads = 0;
  int rd_cyc[$];
  int del_c[$];
  logic [DW-1:0] del_d[$];
  bit            prev_hold = 0;
  logic [DW-1:0] prev_d = '0;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic [CW-1:0] s_wo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    reads = 0;
    rd_cyc.delete();
    del_c.delete();
    del_d.delete();
  endtask

  task automatic step();
    bit exp_v, pop_e, exp_rd, nv;
    int committed;
    logic [DW-1:0] nd;
    @(negedge clk);
    fifo_empty = (fq.size() == 0);
    #1;
    exp_v     = (mq.size() != 0);
    pop_e     = exp_v && m_ready;
    committed = mq.size() + int'(infl) - int'(pop_e);
    exp_rd    = !rst && en && (fq.size() != 0) && (committed <= 1);
    chk("rd_en", {31'd0, fifo_rd_en}, {31'd0, exp_rd});
    chk("m_valid", {31'd0, m_valid}, {31'd0, exp_v});
    if (exp_v) chk("m_data", {16'd0, m_data}, {16'd0, mq[0]});
    chk("words_out", {28'd0, words_out}, mcnt % 16);
    if (prev_hold) begin
      chk("hold_valid", {31'd0, m_valid}, 32'd1);
      chk("hold_data", {16'd0, m_data}, {16'd0, prev_d});
    end
    prev_hold = !rst && m_valid && !m_ready;
    prev_d    = m_data;
    s_valid   = m_valid;
    s_data    = m_data;
    s_wo      = words_out;
    if (fifo_rd_en && !fifo_empty) begin
      reads++;
      rd_cyc.push_back(cyc);
    end
    if (m_valid && m_ready && !rst) begin
      del_c.push_back(cyc);
      del_d.push_back(m_data);
    end
    // model next state
    if (rst) begin
      mq.delete();
      infl = 0;
      mcnt = 0;
    end else begin
      if (pop_e) begin
        void'(mq.pop_front());
        mcnt++;
      end
      if (infl) mq.push_back(infl_word);
      infl = exp_rd;
      if (exp_rd) infl_word = fq[0];
    end
    // FIFO environment: registered read data
    nv = fifo_rd_en && (fq.size() != 0);
    nd = '0;
    if (nv) nd = fq.pop_front();
    @(posedge clk);
    #1;
    if (nv) fifo_data = nd;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int t0;
    // reset
    rst = 1; en = 1; m_ready = 1;
    run(3);
    rst = 0;
    step();
    chk("rst_valid", {31'd0, s_valid}, 32'd0);
    chk("rst_data", {16'd0, s_data}, 32'd0);
    chk("rst_wo", {28'd0, s_wo}, 32'd0);

    // three words, always ready
    clear_logs();
    fq.push_back(16'h1111); fq.push_back(16'h2222); fq.push_back(16'h3333);
    run(8);
    chk("s1_reads", reads, 3);
    chk("s1_rd_consec", rd_cyc[2] - rd_cyc[0], 2);
    chk("s1_lat", del_c[0] - rd_cyc[0], 2);
    chk("s1_del_consec", del_c[2] - del_c[0], 2);
    chk("s1_d0", {16'd0, del_d[0]}, 32'h1111);
    chk("s1_d1", {16'd0, del_d[1]}, 32'h2222);
    chk("s1_d2", {16'd0, del_d[2]}, 32'h3333);
    chk("s1_wo", {28'd0, s_wo}, 32'd3);

    // backpressure: four words, consumer stalled
    clear_logs();
    m_ready = 0;
    fq.push_back(16'hA001); fq.push_back(16'hA002); fq.push_back(16'hA003); fq.push_back(16'hA004);
    run(6);
    chk("s2_reads_stalled", reads, 2);
    chk("s2_valid", {31'd0, s_valid}, 32'd1);
    chk("s2_head", {16'd0, s_data}, 32'hA001);
    m_ready = 1;
    run(8);
    chk("s2_reads", reads, 4);
    chk("s2_ndel", del_d.size(), 4);
    for (int i = 0; i < 4; i++) chk("s2_order", {16'd0, del_d[i]}, 32'hA001 + i);

    // empty FIFO, then a single word
    clear_logs();
    run(6);
    chk("s3_idle_reads", reads, 0);
    chk("s3_idle_valid", {31'd0, s_valid}, 32'd0);
    fq.push_back(16'hABCD);
    run(6);
    chk("s3_ndel", del_d.size(), 1);
    chk("s3_word", {16'd0, del_d[0]}, 32'hABCD);
    chk("s3_wo", {28'd0, s_wo}, 32'd8);

    // eight words with m_ready toggling
    clear_logs();
    for (int i = 0; i < 8; i++) fq.push_back(16'h0B00 + 16'(i));
    for (int i = 0; i < 30; i++) begin
      m_ready = (i % 2 == 0);
      step();
    end
    m_ready = 1;
    run(4);
    chk("s4_ndel", del_d.size(), 8);
    for (int i = 0; i < 8; i++) chk("s4_order", {16'd0, del_d[i]}, 32'h0B00 + i);

    // en drops on the cycle of an accepted read
    clear_logs();
    fq.push_back(16'h5A5A);
    step();
    chk("s5_read", reads, 1);
    en = 0;
    fq.push_back(16'h6B6B);
    run(5);
    chk("s5_reads_off", reads, 1);
    chk("s5_ndel", del_d.size(), 1);
    chk("s5_word", {16'd0, del_d[0]}, 32'h5A5A);
    en = 1;
    run(5);
    chk("s5_word2", {16'd0, del_d[1]}, 32'h6B6B);

    // reset with buffered and in-flight words
    m_ready = 0;
    for (int i = 0; i < 5; i++) fq.push_back(16'hC000 + 16'(i));
    run(4);
    rst = 1;
    step();
    fq.delete();
    rst = 0;
    step();
    chk("s6_valid", {31'd0, s_valid}, 32'd0);
    chk("s6_wo", {28'd0, s_wo}, 32'd0);

    // 17 pops wrap the 4-bit counter to 1
    clear_logs();
    m_ready = 1;
    for (int i = 0; i < 17; i++) fq.push_back(16'hD000 + 16'(i));
    run(25);
    chk("s7_ndel", del_d.size(), 17);
    chk("s7_wo", {28'd0, s_wo}, 32'd1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      en      = ($urandom % 8) != 0;
      m_ready = ($urandom % 3) != 0;
      rst     = ($urandom % 150) == 0;
      if (rst) fq.delete();
      else if (($urandom % 4) != 0 && fq.size() < 20) fq.push_back(16'($urandom));
      step();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
